// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register port with an auto-incrementing
// pointer; bus inputs are synchronised into osc_clk before any decoding.
module i2c_target_regs #(
   parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
   input  logic       osc_clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
      WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
   } state_t;

   state_t     state_q, ack_nxt;
   logic       scl_s1_q, scl_s2_q, scl_h_q;
   logic       sda_s1_q, sda_s2_q, sda_h_q;
   logic [3:0] cnt_q;
   logic [7:0] sh_q, tx_q;
   logic [7:0] reg_addr_q, reg_wdata_q;
   logic       rw_q, ack_on_q, pend_q, ld_q;
   logic       sda_oe_q, reg_wr_q, reg_rd_q, busy_q;
   logic       scl_rise, scl_fall, start_d, stop_d;
   logic [7:0] byte_d;

   assign scl_rise = scl_s2_q & ~scl_h_q;
   assign scl_fall = ~scl_s2_q & scl_h_q;
   assign start_d  = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
   assign stop_d   = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
   assign byte_d   = {sh_q[6:0], sda_s2_q};

   always_comb begin
      ack_nxt = WDATA;
      if (state_q == ADDR_ACK) ack_nxt = rw_q ? RDATA : REG;
   end

   always_ff @(posedge osc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         scl_s1_q    <= 1'b1;
         scl_s2_q    <= 1'b1;
         scl_h_q     <= 1'b1;
         sda_s1_q    <= 1'b1;
         sda_s2_q    <= 1'b1;
         sda_h_q     <= 1'b1;
         cnt_q       <= 4'd0;
         sh_q        <= 8'h00;
         tx_q        <= 8'h00;
         reg_addr_q  <= 8'h00;
         reg_wdata_q <= 8'h00;
         rw_q        <= 1'b0;
         ack_on_q    <= 1'b0;
         pend_q      <= 1'b0;
         ld_q        <= 1'b0;
         sda_oe_q    <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_rd_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         scl_s1_q <= scl_in;
         scl_s2_q <= scl_s1_q;
         scl_h_q  <= scl_s2_q;
         sda_s1_q <= sda_in;
         sda_s2_q <= sda_s1_q;
         sda_h_q  <= sda_s2_q;
         reg_wr_q <= 1'b0;
         reg_rd_q <= 1'b0;
         ld_q     <= reg_rd_q;
         if (ld_q) tx_q <= reg_rdata;
         if (reg_wr_q) reg_addr_q <= reg_addr_q + 8'd1;
         if (start_d) begin
            state_q  <= ADDR;
            cnt_q    <= 4'd0;
            sda_oe_q <= 1'b0;
            ack_on_q <= 1'b0;
            pend_q   <= 1'b0;
         end else if (stop_d) begin
            state_q  <= IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            ack_on_q <= 1'b0;
            pend_q   <= 1'b0;
         end else begin
            case (state_q)
               ADDR, REG, WDATA: if (scl_rise) begin
                  sh_q  <= byte_d;
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     unique case (1'b1)
                        state_q == ADDR: begin
                           if (byte_d[7:1] == SLAVE_ADDR) begin
                              state_q <= ADDR_ACK;
                              busy_q  <= 1'b1;
                              rw_q    <= byte_d[0];
                           end else begin
                              state_q <= WAIT_STOP;
                              busy_q  <= 1'b0;
                           end
                        end
                        state_q == REG: begin
                           reg_addr_q <= byte_d;
                           state_q    <= REG_ACK;
                        end
                        default: begin
                           reg_wdata_q <= byte_d;
                           reg_wr_q    <= 1'b1;
                           state_q     <= WDATA_ACK;
                        end
                     endcase
                  end
               end
               ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
                  if (!ack_on_q) begin
                     sda_oe_q <= 1'b1;
                     ack_on_q <= 1'b1;
                  end else begin
                     sda_oe_q <= 1'b0;
                     ack_on_q <= 1'b0;
                     cnt_q    <= 4'd0;
                     state_q  <= ack_nxt;
                     if (ack_nxt == RDATA) begin
                        reg_rd_q <= 1'b1;
                        pend_q   <= 1'b1;
                     end
                  end
               end
               // bit 7 goes out once the fetched byte is in and SCL is low
               RDATA: begin
                  if (pend_q) begin
                     if (!reg_rd_q && !ld_q && !scl_s2_q) begin
                        sda_oe_q <= ~tx_q[7];
                        pend_q   <= 1'b0;
                     end
                  end else if (scl_rise) begin
                     cnt_q <= cnt_q + 4'd1;
                  end else if (scl_fall) begin
                     if (cnt_q == 4'd8) begin
                        sda_oe_q <= 1'b0;
                        state_q  <= RDATA_ACK;
                     end else begin
                        sda_oe_q <= ~tx_q[6];
                        tx_q     <= {tx_q[6:0], 1'b0};
                     end
                  end
               end
               RDATA_ACK: if (scl_rise) begin
                  cnt_q <= 4'd0;
                  if (!sda_s2_q) begin
                     reg_addr_q <= reg_addr_q + 8'd1;
                     reg_rd_q   <= 1'b1;
                     pend_q     <= 1'b1;
                     state_q    <= RDATA;
                  end else begin
                     state_q <= WAIT_STOP;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign sda_oe    = sda_oe_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_wr    = reg_wr_q;
   assign reg_rd    = reg_rd_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-level bench: bit-banged controller, register-file model, and a
// strobe scoreboard fed by expected write/read events.
module tb_i2c_target_regs;

   localparam int H = 16;

   logic       osc_clk = 1'b0;
   logic       rst_n;
   logic       scl_m, sda_m;
   logic       scl_in, sda_in, sda_oe;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_wr, reg_rd, busy;

   typedef logic [7:0] bq_t [$];

   int n_chk = 0;
   int n_fail = 0;
   int oe_cnt = 0;
   int busy_cnt = 0;
   logic [15:0] exp_wr [$];
   logic [7:0]  exp_rd [$];
   logic [7:0]  mdl [256];
   logic [7:0]  rf [256];
   bit          rf_init = 1'b0;
   logic [7:0]  ptr;

   always #5 osc_clk = ~osc_clk;

   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   i2c_target_regs #(.SLAVE_ADDR(7'h1A)) dut (
      .osc_clk(osc_clk), .rst_n(rst_n),
      .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_wr(reg_wr), .reg_rd(reg_rd),
      .reg_rdata(reg_rdata), .busy(busy)
   );

   function automatic logic [7:0] seedv(input logic [7:0] i);
      if (i == 8'h10) return 8'hA5;
      if (i == 8'h11) return 8'h3C;
      return i * 8'd29 + 8'd7;
   endfunction

   function automatic void chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   always @(posedge osc_clk) begin
      if (!rf_init) begin
         for (int i = 0; i < 256; i++) rf[i] <= seedv(8'(i));
         rf_init <= 1'b1;
      end else if (reg_wr) begin
         rf[reg_addr] <= reg_wdata;
      end
      if (reg_rd) reg_rdata <= rf[reg_addr];
   end

   always @(negedge osc_clk) begin
      if (rst_n) begin
         if (sda_oe) oe_cnt <= oe_cnt + 1;
         if (busy) busy_cnt <= busy_cnt + 1;
         if (reg_wr) begin
            if (exp_wr.size() == 0) begin
               chk("wr_unexpected", int'(reg_addr), -1);
            end else begin
               logic [15:0] e;
               e = exp_wr.pop_front();
               chk("wr_addr", int'(reg_addr), int'(e[15:8]));
               chk("wr_data", int'(reg_wdata), int'(e[7:0]));
            end
         end
         if (reg_rd) begin
            if (exp_rd.size() == 0) begin
               chk("rd_unexpected", int'(reg_addr), -1);
            end else begin
               logic [7:0] a;
               a = exp_rd.pop_front();
               chk("rd_addr", int'(reg_addr), int'(a));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge osc_clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; tick(H / 2);
      scl_m = 1'b1; tick(H);
      sda_m = 1'b0; tick(H);
      scl_m = 1'b0; tick(H / 2);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(H / 2);
      scl_m = 1'b1; tick(H);
      sda_m = 1'b1; tick(H);
   endtask

   task automatic send_bit(input logic b);
      sda_m = b; tick(H / 2);
      scl_m = 1'b1; tick(H);
      scl_m = 1'b0; tick(H / 2);
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; tick(H / 2);
      scl_m = 1'b1; tick(H / 2);
      b = sda_in; tick(H / 2);
      scl_m = 1'b0; tick(H / 2);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      logic b;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         recv_bit(b);
         d = {d[6:0], b};
      end
      send_bit(nack);
   endtask

   task automatic do_write(input logic [7:0] ra, input bq_t data);
      logic ack;
      i2c_start();
      write_byte(8'h34, ack); chk("ack_addr_w", int'(ack), 0);
      chk("busy_on", int'(busy), 1);
      write_byte(ra, ack); chk("ack_reg", int'(ack), 0);
      ptr = ra;
      foreach (data[j]) begin
         exp_wr.push_back({ptr, data[j]});
         mdl[ptr] = data[j];
         ptr = ptr + 8'd1;
         write_byte(data[j], ack); chk("ack_data", int'(ack), 0);
      end
      i2c_stop();
      chk("busy_off", int'(busy), 0);
      chk("ptr_after_wr", int'(reg_addr), int'(ptr));
   endtask

   task automatic do_read(input bit set_reg, input logic [7:0] ra, input int n);
      logic ack;
      logic [7:0] d;
      i2c_start();
      if (set_reg) begin
         write_byte(8'h34, ack); chk("ack_addr_w", int'(ack), 0);
         write_byte(ra, ack); chk("ack_reg", int'(ack), 0);
         ptr = ra;
         i2c_start();
      end
      exp_rd.push_back(ptr);
      write_byte(8'h35, ack); chk("ack_addr_r", int'(ack), 0);
      for (int j = 0; j < n; j++) begin
         if (j != n - 1) exp_rd.push_back(ptr + 8'd1);
         read_byte(d, j == n - 1);
         chk("rd_byte", int'(d), int'(mdl[ptr]));
         if (j != n - 1) ptr = ptr + 8'd1;
      end
      i2c_stop();
      chk("busy_off_rd", int'(busy), 0);
      chk("ptr_after_rd", int'(reg_addr), int'(ptr));
   endtask

   task automatic do_bad(input logic [6:0] a);
      logic ack;
      int oe0, bz0;
      oe0 = oe_cnt;
      bz0 = busy_cnt;
      i2c_start();
      write_byte({a, 1'b0}, ack); chk("nack_addr", int'(ack), 1);
      write_byte(8'($urandom), ack); chk("nack_data", int'(ack), 1);
      i2c_stop();
      chk("bad_no_oe", oe_cnt - oe0, 0);
      chk("bad_no_busy", busy_cnt - bz0, 0);
   endtask

   initial begin
      logic ack;
      logic [7:0] ra;
      logic [6:0] ba;
      int oe0;
      bq_t q;
      for (int i = 0; i < 256; i++) mdl[i] = seedv(8'(i));
      rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
      tick(5);
      chk("rst_sda_oe", int'(sda_oe), 0);
      chk("rst_reg_wr", int'(reg_wr), 0);
      chk("rst_reg_rd", int'(reg_rd), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_reg_addr", int'(reg_addr), 0);
      chk("rst_reg_wdata", int'(reg_wdata), 0);
      rst_n = 1'b1;
      tick(5);
      ptr = 8'h00;

      q = '{8'h0A};
      do_write(8'h07, q);
      do_bad(7'h35);
      q = '{8'h11, 8'h22, 8'h33};
      do_write(8'hFE, q);
      do_read(1'b1, 8'h10, 2);

      i2c_start();
      write_byte(8'h34, ack); chk("abort_ack_a", int'(ack), 0);
      write_byte(8'h20, ack); chk("abort_ack_r", int'(ack), 0);
      ptr = 8'h20;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      i2c_stop();
      chk("abort_ptr", int'(reg_addr), int'(ptr));
      q = '{8'h5A};
      do_write(8'h21, q);

      i2c_start();
      write_byte(8'h34, ack); chk("rst_ack_a", int'(ack), 0);
      for (int i = 7; i >= 0; i--) send_bit(ra[0] | 1'b1 ? 1'(8'h40 >> i) : 1'b0);
      sda_m = 1'b1; tick(H / 2);
      chk("ack_before_rst", int'(sda_oe), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_sda_oe", int'(sda_oe), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_addr", int'(reg_addr), 0);
      chk("rst_mid_wdata", int'(reg_wdata), 0);
      chk("rst_mid_wr", int'(reg_wr), 0);
      chk("rst_mid_rd", int'(reg_rd), 0);
      scl_m = 1'b1;
      tick(H);
      rst_n = 1'b1;
      tick(H);
      ptr = 8'h00;
      oe0 = oe_cnt;
      scl_m = 1'b0; tick(H / 2);
      for (int i = 0; i < 18; i++) send_bit(1'($urandom));
      i2c_stop();
      chk("no_start_oe", oe_cnt - oe0, 0);
      chk("no_start_ptr", int'(reg_addr), 0);

      for (int t = 0; t < 12; t++) begin
         ra = 8'($urandom);
         case ($urandom_range(0, 2))
            0: begin
               q = {};
               for (int j = 0; j < int'($urandom_range(1, 4)); j++)
                  q.push_back(8'($urandom));
               do_write(ra, q);
            end
            1: do_read(1'($urandom), ra, int'($urandom_range(1, 3)));
            default: begin
               ba = 7'($urandom);
               if (ba == 7'h1A) ba = 7'h1B;
               do_bad(ba);
            end
         endcase
      end

      tick(H);
      chk("wr_left", exp_wr.size(), 0);
      chk("rd_left", exp_rd.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
